rv_multicycle_controller: RTL and testbench

//  Multi-cycle RV32I control unit: successor to the single-register ALU-op controller.

---
 rtl/rv_multicycle_controller_pkg.sv | 180 ++++++++++++++++++
 rtl/rv_multicycle_controller_if.sv | 21 ++
 rtl/rv_multicycle_controller_imm_gen.sv | 27 ++
 rtl/rv_multicycle_controller.sv | 143 ++++++++++++++
 tb/tb_rv_multicycle_controller.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, ALU ops,
// FSM states, select codes, the registered control bundle and the decoder.
package rv_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  localparam logic [1:0] SRC_A_RS1  = 2'd0;
  localparam logic [1:0] SRC_A_PC   = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;
  localparam logic       SRC_B_RS2  = 1'b0;
  localparam logic       SRC_B_IMM  = 1'b1;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_REL   = 2'd1;
  localparam logic [1:0] PC_JALR  = 2'd2;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CLS_OP, CLS_OP_IMM, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR,
    CLS_BRANCH, CLS_LOAD, CLS_STORE, CLS_FENCE, CLS_ILLEGAL
  } insn_cls_e;

  // Registered control bundle; every controller output comes from here or the IR.
  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       reg_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic [1:0] wb_sel;
    logic [1:0] alu_src_a;
    logic       alu_src_b;
    alu_op_e    alu_op;
    logic       illegal;
  } ctrl_t;

  typedef struct packed {
    insn_cls_e  cls;
    alu_op_e    alu_op;
    logic [1:0] src_a;
    logic       src_b;
  } decode_t;

  // funct3 -> ALU op for register/immediate arithmetic; alt selects SUB/SRA.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Classify an instruction and pick ALU op/operands; anything unrecognised is illegal.
  function automatic decode_t decode_insn(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic fence_nop);
    decode_t d;
    d.cls    = CLS_ILLEGAL;
    d.alu_op = ALU_ADD;
    d.src_a  = SRC_A_RS1;
    d.src_b  = SRC_B_RS2;
    case (opc)
      OPC_OP: begin
        if (f7 == 7'h00) begin
          d.cls    = CLS_OP;
          d.alu_op = alu_from_f3(f3, 1'b0);
        end else if (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)) begin
          d.cls    = CLS_OP;
          d.alu_op = alu_from_f3(f3, 1'b1);
        end
      end
      OPC_OP_IMM: begin
        d.src_b = SRC_B_IMM;
        if (f3 == 3'b001) begin
          if (f7 == 7'h00) begin
            d.cls    = CLS_OP_IMM;
            d.alu_op = ALU_SLL;
          end
        end else if (f3 == 3'b101) begin
          if (f7 == 7'h00 || f7 == 7'h20) begin
            d.cls    = CLS_OP_IMM;
            d.alu_op = alu_from_f3(f3, f7[5]);
          end
        end else begin
          d.cls    = CLS_OP_IMM;
          d.alu_op = alu_from_f3(f3, 1'b0);
        end
      end
      OPC_LUI: begin
        d.cls    = CLS_LUI;
        d.alu_op = ALU_PASSB;
        d.src_a  = SRC_A_ZERO;
        d.src_b  = SRC_B_IMM;
      end
      OPC_AUIPC: begin
        d.cls   = CLS_AUIPC;
        d.src_a = SRC_A_PC;
        d.src_b = SRC_B_IMM;
      end
      OPC_JAL: begin
        d.cls   = CLS_JAL;
        d.src_a = SRC_A_PC;
        d.src_b = SRC_B_IMM;
      end
      OPC_JALR: begin
        d.src_b = SRC_B_IMM;
        if (f3 == 3'b000) d.cls = CLS_JALR;
      end
      OPC_BRANCH: begin
        case (f3)
          3'b000, 3'b001: begin d.cls = CLS_BRANCH; d.alu_op = ALU_SUB;  end
          3'b100, 3'b101: begin d.cls = CLS_BRANCH; d.alu_op = ALU_SLT;  end
          3'b110, 3'b111: begin d.cls = CLS_BRANCH; d.alu_op = ALU_SLTU; end
          default:        d.cls = CLS_ILLEGAL;
        endcase
      end
      OPC_LOAD: begin
        d.src_b = SRC_B_IMM;
        if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b101)
          d.cls = CLS_LOAD;
      end
      OPC_STORE: begin
        d.src_b = SRC_B_IMM;
        if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) d.cls = CLS_STORE;
      end
      OPC_MISC_MEM: begin
        if (fence_nop && (f3 == 3'b000 || f3 == 3'b001)) d.cls = CLS_FENCE;
      end
      default: d.cls = CLS_ILLEGAL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rv_multicycle_controller_if.sv
// Instruction/data memory handshake bundle between controller and memories.
interface rv_multicycle_controller_if;
  import rv_ctrl_pkg::*;

  logic            imem_req;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            dmem_req;
  logic            dmem_we;
  logic            dmem_ack;

  modport master (
    output imem_req, dmem_req, dmem_we,
    input  imem_ack, imem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we,
    output imem_ack, imem_rdata, dmem_ack
  );
endinterface

// File: rtl/rv_multicycle_controller_imm_gen.sv
// Immediate generator: picks I/S/B/U/J layout from the opcode and sign-extends.
module rv_imm_gen
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned REG_DATA_WIDTH = 32
) (
  input  logic [XLEN-1:0]           ir,
  output logic [REG_DATA_WIDTH-1:0] imm
);

  logic [XLEN-1:0] imm32;

  // Reassemble the immediate bits for the instruction format.
  always_comb begin
    imm32 = '0;
    case (ir[6:0])
      OPC_STORE:           imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OPC_BRANCH:          imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:  imm32 = {ir[31:12], 12'h000};
      OPC_JAL:             imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:             imm32 = {{20{ir[31]}}, ir[31:20]};
    endcase
  end

  assign imm = REG_DATA_WIDTH'($signed(imm32));

endmodule

// File: rtl/rv_multicycle_controller.sv
// Multi-cycle RV32I control unit: fetch/decode/exec/mem/writeback sequencing
// with registered strobes and a sticky illegal-instruction trap.
module rv_multicycle_controller
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned REG_DATA_WIDTH = 32,
  parameter int unsigned ALU_OP_WIDTH   = 4,
  parameter int unsigned FENCE_AS_NOP   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  rv_multicycle_controller_if.master    mem,
  input  logic                          branch_taken,
  output logic [ALU_OP_WIDTH-1:0]       alu_op,
  output logic [1:0]                    alu_src_a,
  output logic                          alu_src_b,
  output logic [4:0]                    rs1,
  output logic [4:0]                    rs2,
  output logic [4:0]                    rd,
  output logic [REG_DATA_WIDTH-1:0]     imm,
  output logic [1:0]                    wb_sel,
  output logic                          reg_we,
  output logic                          pc_we,
  output logic [1:0]                    pc_sel,
  output logic                          illegal
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] ir_q;
  ctrl_t           ctrl_q, ctrl_d;
  decode_t         dec;
  logic            fetch_done;
  logic            mem_done;

  assign dec = decode_insn(ir_q[6:0], ir_q[14:12], ir_q[31:25], FENCE_AS_NOP != 0);

  // An ack only counts while our own request is up, so stale acks after reset are dropped.
  assign fetch_done = ctrl_q.imem_req & mem.imem_ack;
  assign mem_done   = ctrl_q.dmem_req & mem.dmem_ack;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  // Instruction register and registered control outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q   <= NOP_INSN;
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      if (state_q == ST_FETCH && fetch_done) ir_q <= mem.imem_rdata;
    end
  end

  // Next state, plus the control word for the state being entered.
  always_comb begin
    state_d = state_q;
    ctrl_d  = '0;

    case (state_q)
      ST_FETCH:  if (fetch_done) state_d = ST_DECODE;
      ST_DECODE: state_d = (dec.cls == CLS_ILLEGAL) ? ST_TRAP : ST_EXEC;
      ST_EXEC: begin
        case (dec.cls)
          CLS_BRANCH, CLS_FENCE: state_d = ST_FETCH;
          CLS_LOAD, CLS_STORE:   state_d = ST_MEM;
          default:               state_d = ST_WB;
        endcase
      end
      ST_MEM:    if (mem_done) state_d = (dec.cls == CLS_STORE) ? ST_FETCH : ST_WB;
      ST_WB:     state_d = ST_FETCH;
      ST_TRAP:   state_d = ST_TRAP;
      default:   state_d = ST_FETCH;
    endcase

    case (state_d)
      ST_FETCH: ctrl_d.imem_req = 1'b1;
      ST_EXEC: begin
        ctrl_d.alu_op    = dec.alu_op;
        ctrl_d.alu_src_a = dec.src_a;
        ctrl_d.alu_src_b = dec.src_b;
      end
      ST_MEM: begin
        ctrl_d.alu_op    = dec.alu_op;
        ctrl_d.alu_src_a = dec.src_a;
        ctrl_d.alu_src_b = dec.src_b;
        ctrl_d.dmem_req  = 1'b1;
        ctrl_d.dmem_we   = (dec.cls == CLS_STORE);
      end
      ST_WB: begin
        ctrl_d.alu_op    = dec.alu_op;
        ctrl_d.alu_src_a = dec.src_a;
        ctrl_d.alu_src_b = dec.src_b;
        ctrl_d.reg_we    = (ir_q[11:7] != 5'd0);
        ctrl_d.pc_we     = 1'b1;
        case (dec.cls)
          CLS_JAL:  begin ctrl_d.pc_sel = PC_REL;  ctrl_d.wb_sel = WB_PC4; end
          CLS_JALR: begin ctrl_d.pc_sel = PC_JALR; ctrl_d.wb_sel = WB_PC4; end
          CLS_LOAD: ctrl_d.wb_sel = WB_MEM;
          default:  ctrl_d.wb_sel = WB_ALU;
        endcase
      end
      ST_TRAP:  ctrl_d.illegal = 1'b1;
      default:  ctrl_d.imem_req = 1'b0;
    endcase

    // Branch/fence/store retire straight into FETCH; their PC commit rides on the first fetch cycle.
    if (state_q == ST_EXEC && state_d == ST_FETCH) begin
      ctrl_d.pc_we  = 1'b1;
      ctrl_d.pc_sel = (dec.cls == CLS_BRANCH && branch_taken) ? PC_REL : PC_PLUS4;
    end
    if (state_q == ST_MEM && state_d == ST_FETCH) begin
      ctrl_d.pc_we  = 1'b1;
      ctrl_d.pc_sel = PC_PLUS4;
    end
  end

  rv_imm_gen #(
    .REG_DATA_WIDTH (REG_DATA_WIDTH)
  ) u_imm_gen (
    .ir  (ir_q),
    .imm (imm)
  );

  assign mem.imem_req = ctrl_q.imem_req;
  assign mem.dmem_req = ctrl_q.dmem_req;
  assign mem.dmem_we  = ctrl_q.dmem_we;
  assign alu_op       = ALU_OP_WIDTH'(ctrl_q.alu_op);
  assign alu_src_a    = ctrl_q.alu_src_a;
  assign alu_src_b    = ctrl_q.alu_src_b;
  assign wb_sel       = ctrl_q.wb_sel;
  assign reg_we       = ctrl_q.reg_we;
  assign pc_we        = ctrl_q.pc_we;
  assign pc_sel       = ctrl_q.pc_sel;
  assign illegal      = ctrl_q.illegal;
  assign rs1          = ir_q[19:15];
  assign rs2          = ir_q[24:20];
  assign rd           = ir_q[11:7];

endmodule

// File: tb/tb_rv_multicycle_controller.sv
// Directed bench for rv_multicycle_controller: hand-computed expectations,
// inputs driven and outputs sampled on the falling clock edge.
module tb_rv_multicycle_controller;

  logic        clk;
  logic        reset;
  logic        branch_taken;
  logic [3:0]  alu_op;
  logic [1:0]  alu_src_a;
  logic        alu_src_b;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic [1:0]  wb_sel;
  logic        reg_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  rv_multicycle_controller_if bus ();

  rv_multicycle_controller #(
    .REG_DATA_WIDTH (32),
    .ALU_OP_WIDTH   (4),
    .FENCE_AS_NOP   (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mem          (bus),
    .branch_taken (branch_taken),
    .alu_op       (alu_op),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .rs1          (rs1),
    .rs2          (rs2),
    .rd           (rd),
    .imm          (imm),
    .wb_sel       (wb_sel),
    .reg_we       (reg_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .illegal      (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for a fetch request, then answer it in the same cycle.
  task automatic fetch(input logic [31:0] word);
    int n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("fetch_req", 32'(bus.imem_req), 32'd1);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Instruction that retires through WB with a one-cycle fetch ack.
  task automatic run_wb(input string nm, input logic [31:0] word, input logic [3:0] e_op,
                        input logic [1:0] e_a, input logic e_b, input logic [4:0] e_rd,
                        input logic [1:0] e_wb, input logic [1:0] e_ps, input logic [31:0] e_imm);
    fetch(word);
    check({nm, "_imm"}, imm, e_imm);
    check({nm, "_rd"}, 32'(rd), 32'(e_rd));
    @(negedge clk);
    check({nm, "_alu_op"}, 32'(alu_op), 32'(e_op));
    check({nm, "_src_a"}, 32'(alu_src_a), 32'(e_a));
    check({nm, "_src_b"}, 32'(alu_src_b), 32'(e_b));
    check({nm, "_exec_we"}, 32'({reg_we, pc_we}), 32'd0);
    @(negedge clk);
    check({nm, "_reg_we"}, 32'(reg_we), (e_rd != 5'd0) ? 32'd1 : 32'd0);
    check({nm, "_pc_we"}, 32'(pc_we), 32'd1);
    check({nm, "_pc_sel"}, 32'(pc_sel), 32'(e_ps));
    check({nm, "_wb_sel"}, 32'(wb_sel), 32'(e_wb));
    @(negedge clk);
    check({nm, "_after"}, 32'({reg_we, pc_we, bus.imem_req}), 32'b001);
  endtask

  // Branch through EXEC with a given compare result.
  task automatic run_branch(input string nm, input logic [31:0] word, input logic taken,
                            input logic [3:0] e_op);
    fetch(word);
    check({nm, "_imm"}, imm, 32'd8);
    check({nm, "_rs"}, 32'({rs1, rs2}), 32'({5'd1, 5'd2}));
    @(negedge clk);
    check({nm, "_alu_op"}, 32'(alu_op), 32'(e_op));
    check({nm, "_src_b"}, 32'(alu_src_b), 32'd0);
    check({nm, "_exec_pc_we"}, 32'(pc_we), 32'd0);
    branch_taken = taken;
    @(negedge clk);
    branch_taken = 1'b0;
    check({nm, "_pc_we"}, 32'(pc_we), 32'd1);
    check({nm, "_pc_sel"}, 32'(pc_sel), taken ? 32'd1 : 32'd0);
    check({nm, "_reg_we"}, 32'(reg_we), 32'd0);
    check({nm, "_req"}, 32'(bus.imem_req), 32'd1);
    @(negedge clk);
    check({nm, "_pc_pulse"}, 32'({pc_we, reg_we}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_req;
    reset          = 1'b1;
    branch_taken   = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    bus.dmem_ack   = 1'b0;

    // Reset values and stale-ack rejection.
    @(negedge clk);
    check("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
    check("rst_strobes", 32'({reg_we, pc_we, illegal}), 32'd0);
    check("rst_alu", 32'({alu_op, alu_src_a, alu_src_b}), 32'd0);
    check("rst_ir_fields", 32'({rs1, rs2, rd}), 32'd0);
    check("rst_imm", imm, 32'd0);
    reset        = 1'b0;
    bus.imem_ack = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    check("req_after_reset", 32'(bus.imem_req), 32'd1);

    // Reset in the middle of a fetch drops the request immediately.
    #2 reset = 1'b1;
    #1 check("req_async_drop", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check("illegal_after_rst", 32'(illegal), 32'd0);
    @(negedge clk);
    check("req_rearm", 32'(bus.imem_req), 32'd1);

    //     name     word          op     a     b     rd    wb    ps    imm
    run_wb("addi",  32'h00500093, 4'd0,  2'd0, 1'b1, 5'd1, 2'd0, 2'd0, 32'd5);
    run_wb("add_x0",32'h00208033, 4'd0,  2'd0, 1'b0, 5'd0, 2'd0, 2'd0, 32'h002);
    run_wb("sub",   32'h402081B3, 4'd1,  2'd0, 1'b0, 5'd3, 2'd0, 2'd0, 32'h402);
    run_wb("srai",  32'h4030D213, 4'd7,  2'd0, 1'b1, 5'd4, 2'd0, 2'd0, 32'h403);
    run_wb("lui",   32'h123452B7, 4'd10, 2'd2, 1'b1, 5'd5, 2'd0, 2'd0, 32'h12345000);
    run_wb("auipc", 32'h00001317, 4'd0,  2'd1, 1'b1, 5'd6, 2'd0, 2'd0, 32'h1000);
    run_wb("jal",   32'h008000EF, 4'd0,  2'd1, 1'b1, 5'd1, 2'd2, 2'd1, 32'd8);
    run_wb("jalr",  32'h000100E7, 4'd0,  2'd0, 1'b1, 5'd1, 2'd2, 2'd2, 32'd0);

    // lw x2,8(x1) with three wait cycles before dmem_ack.
    fetch(32'h0080A103);
    check("lw_imm", imm, 32'd8);
    check("lw_regs", 32'({rs1, rd}), 32'({5'd1, 5'd2}));
    @(negedge clk);
    check("lw_exec", 32'({alu_op, alu_src_b, bus.dmem_req}), 32'({4'd0, 1'b1, 1'b0}));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("lw_dmem_req", 32'({bus.dmem_req, bus.dmem_we, reg_we}), 32'b100);
      if (i == 3) bus.dmem_ack = 1'b1;
    end
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    check("lw_wb", 32'({bus.dmem_req, reg_we, pc_we}), 32'b011);
    check("lw_wb_sel", 32'(wb_sel), 32'd1);
    check("lw_pc_sel", 32'(pc_sel), 32'd0);
    @(negedge clk);
    check("lw_done", 32'({reg_we, pc_we, bus.imem_req}), 32'b001);

    run_branch("beq_t",  32'h00208463, 1'b1, 4'd1);
    run_branch("beq_n",  32'h00208463, 1'b0, 4'd1);
    run_branch("blt_t",  32'h0020C463, 1'b1, 4'd3);
    run_branch("bltu_n", 32'h0020E463, 1'b0, 4'd4);

    // sw x2,4(x1), single-cycle ack, then PC commit on return to FETCH.
    fetch(32'h0020A223);
    check("sw_imm", imm, 32'd4);
    @(negedge clk);
    check("sw_exec", 32'({alu_op, alu_src_b}), 32'({4'd0, 1'b1}));
    @(negedge clk);
    check("sw_mem", 32'({bus.dmem_req, bus.dmem_we, pc_we}), 32'b110);
    bus.dmem_ack = 1'b1;
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    check("sw_retire", 32'({bus.dmem_req, reg_we, pc_we, bus.imem_req}), 32'b0011);
    check("sw_pc_sel", 32'(pc_sel), 32'd0);

    // FENCE retires as a NOP.
    fetch(32'h0000000F);
    @(negedge clk);
    check("fence_exec", 32'({pc_we, illegal}), 32'd0);
    @(negedge clk);
    check("fence_retire", 32'({pc_we, reg_we, illegal, bus.imem_req}), 32'b1001);

    // SLLI with funct7=0x20 is illegal.
    fetch(32'h40109093);
    @(negedge clk);
    check("slli_bad_illegal", 32'(illegal), 32'd1);
    do_reset();
    check("illegal_cleared", 32'(illegal), 32'd0);

    // All-ones word traps; fetch acks are ignored from then on.
    fetch(32'hFFFFFFFF);
    check("trap_decode", 32'(illegal), 32'd0);
    @(negedge clk);
    check("trap_illegal", 32'(illegal), 32'd1);
    bus.imem_ack = 1'b1;
    saw_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.imem_req !== 1'b0 || pc_we !== 1'b0 || reg_we !== 1'b0) saw_req = 1'b1;
    end
    bus.imem_ack = 1'b0;
    check("trap_quiet", 32'(saw_req), 32'd0);
    check("trap_sticky", 32'(illegal), 32'd1);
    do_reset();
    check("trap_reset", 32'({illegal, bus.imem_req}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
